// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: programs the UART, then round-robins NUM_REQ byte streams onto its single transmitter
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] UART_BASE = 32'h0,
    parameter logic [31:0] CTRL_INIT = 32'h3,
    parameter logic [31:0] BAUD_DIV  = 32'h1B8,
    parameter logic [15:0] BUSY_TMO  = 16'hFFFF,
    parameter logic [15:0] LOCK_TMO  = 16'd1024
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_lock_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 err_o,
    output logic                 uart_ce_o,
    output logic                 uart_we_o,
    output logic [3:0]           uart_sel_o,
    output logic [31:0]          uart_addr_o,
    output logic [31:0]          uart_txdata_o,
    input  logic [31:0]          uart_rxdata_i
);
    localparam int PW = NUM_REQ > 2 ? 2 : 1;
    typedef enum logic [2:0] {INIT_CTRL, INIT_BAUD, IDLE, POLL, WRITE, SETTLE} state_t;
    state_t state;
    logic [PW-1:0] rr_ptr, owner, win, start;
    logic locked, cap_lock, found, expired, busy, done;
    logic [7:0] cap_byte;
    logic [15:0] busy_cnt, lock_cnt;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_REQ);
    endfunction

    assign busy = |(uart_rxdata_i & 32'h1);
    assign expired = locked && !req_valid_i[owner] && lock_cnt >= LOCK_TMO - 16'd1;
    assign start = expired ? wrap(int'(owner) + 1) : rr_ptr;
    assign done = state == POLL && (!busy || busy_cnt == BUSY_TMO);

    // an expiring lock no longer restricts eligibility in the same cycle
    always_comb begin
        found = 1'b0;
        win = owner;
        if (locked && !expired)
            found = req_valid_i[owner];
        else
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (req_valid_i[wrap(int'(start) + i)]) begin
                    found = 1'b1;
                    win = wrap(int'(start) + i);
                end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state <= INIT_CTRL;
            rr_ptr <= '0;
            owner <= '0;
            locked <= 1'b0;
            cap_lock <= 1'b0;
            cap_byte <= '0;
            busy_cnt <= '0;
            lock_cnt <= '0;
            req_ready_o <= '0;
            grant_o <= '0;
            err_o <= 1'b0;
            uart_ce_o <= 1'b0;
            uart_we_o <= 1'b0;
            uart_sel_o <= '0;
            uart_addr_o <= '0;
            uart_txdata_o <= '0;
        end else begin
            uart_ce_o <= 1'b0;
            uart_we_o <= 1'b0;
            uart_sel_o <= '0;
            uart_addr_o <= '0;
            uart_txdata_o <= '0;
            req_ready_o <= '0;
            case (state)
                // ce still low means the CTRL write has not been issued yet
                INIT_CTRL: begin
                    uart_ce_o <= 1'b1;
                    uart_we_o <= 1'b1;
                    uart_sel_o <= 4'hF;
                    uart_addr_o <= UART_BASE | (uart_ce_o ? 32'h8 : 32'h0);
                    uart_txdata_o <= uart_ce_o ? BAUD_DIV : CTRL_INIT;
                    if (uart_ce_o) state <= INIT_BAUD;
                end
                INIT_BAUD: state <= IDLE;
                IDLE: begin
                    lock_cnt <= (locked && !found && !expired) ? lock_cnt + {15'd0, lock_cnt != 16'hFFFF} : '0;
                    if (expired) begin
                        locked <= 1'b0;
                        rr_ptr <= start;
                        grant_o <= '0;
                    end
                    if (found) begin
                        state <= POLL;
                        owner <= win;
                        cap_byte <= req_data_i[8*win +: 8];
                        cap_lock <= req_lock_i[win];
                        grant_o <= NUM_REQ'(1) << win;
                        uart_ce_o <= 1'b1;
                        uart_sel_o <= 4'hF;
                        uart_addr_o <= UART_BASE | 32'h4;
                    end
                end
                POLL: begin
                    busy_cnt <= done ? '0 : busy_cnt + {15'd0, busy_cnt != 16'hFFFF};
                    if (!busy) begin
                        state <= WRITE;
                        uart_ce_o <= 1'b1;
                        uart_we_o <= 1'b1;
                        uart_sel_o <= 4'hF;
                        uart_addr_o <= UART_BASE | 32'hC;
                        uart_txdata_o <= {24'h0, cap_byte};
                    end else if (!done) begin
                        uart_ce_o <= 1'b1;
                        uart_sel_o <= 4'hF;
                        uart_addr_o <= UART_BASE | 32'h4;
                    end else begin
                        state <= SETTLE;
                        err_o <= 1'b1;
                    end
                    if (done) begin
                        req_ready_o <= NUM_REQ'(1) << owner;
                        locked <= cap_lock;
                        if (!cap_lock) rr_ptr <= wrap(int'(owner) + 1);
                    end
                end
                WRITE: state <= SETTLE;
                SETTLE: begin
                    state <= IDLE;
                    if (!locked) grant_o <= '0;
                end
                default: state <= INIT_CTRL;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of init, round-robin, locking, busy polling and async reset
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic n_rst_i;
    logic [1:0] req_valid_i, req_lock_i, req_ready_o, grant_o;
    logic [15:0] req_data_i;
    logic err_o, uart_ce_o, uart_we_o;
    logic [3:0] uart_sel_o;
    logic [31:0] uart_addr_o, uart_txdata_o, uart_rxdata_i;
    int n_checks = 0, n_fail = 0, cyc = 0, n_reads = 0, busy_seen = 0, busy_lim = 0;
    int n_ready[2];
    logic [8:0] q0[$], q1[$];
    logic [31:0] wr_addr[$], wr_data[$], wr_grant[$];
    int wr_cyc[$];
    logic [7:0] exp_c[4] = '{8'hB1, 8'hA0, 8'hB1, 8'hA0};
    logic [1:0] exp_cg[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [7:0] exp_d[5] = '{8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
    logic [1:0] exp_dg[5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

    uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TMO(16'd12), .LOCK_TMO(16'd6)) dut (
        .clk_i(clk), .n_rst_i(n_rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_lock_i(req_lock_i), .req_ready_o(req_ready_o), .grant_o(grant_o), .err_o(err_o),
        .uart_ce_o(uart_ce_o), .uart_we_o(uart_we_o), .uart_sel_o(uart_sel_o),
        .uart_addr_o(uart_addr_o), .uart_txdata_o(uart_txdata_o), .uart_rxdata_i(uart_rxdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART status model: tx_busy stays set for a chosen number of STATUS reads; rx_over is always set
    assign uart_rxdata_i = {30'h0, 1'b1, busy_seen < busy_lim};
    always @(posedge clk)
        if (uart_ce_o && !uart_we_o && uart_addr_o == 32'h4 && busy_seen < busy_lim) busy_seen <= busy_seen + 1;

    // bus monitor plus requesters that hold each byte until its ready pulse
    always @(negedge clk) begin
        logic [8:0] h0, h1;
        if (uart_ce_o && uart_we_o) begin
            wr_addr.push_back(uart_addr_o);
            wr_data.push_back(uart_txdata_o);
            wr_grant.push_back({30'h0, grant_o});
            wr_cyc.push_back(cyc);
        end
        if (uart_ce_o && !uart_we_o) n_reads++;
        if (req_ready_o[0]) begin n_ready[0]++; if (q0.size() != 0) void'(q0.pop_front()); end
        if (req_ready_o[1]) begin n_ready[1]++; if (q1.size() != 0) void'(q1.pop_front()); end
        h0 = q0.size() != 0 ? q0[0] : 9'h0;
        h1 = q1.size() != 0 ? q1[0] : 9'h0;
        req_valid_i = {q1.size() != 0, q0.size() != 0};
        req_data_i = {h1[7:0], h0[7:0]};
        req_lock_i = {h1[8], h0[8]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wr_addr.delete(); wr_data.delete(); wr_grant.delete(); wr_cyc.delete();
        n_reads = 0; n_ready[0] = 0; n_ready[1] = 0;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || uart_ce_o) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < max, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_rst_i = 1'b0;
        n_ready[0] = 0; n_ready[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_ce", {uart_ce_o, uart_we_o, uart_sel_o}, 0);
        check("rst_addr", uart_addr_o, 0);
        check("rst_data", uart_txdata_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_err", err_o, 0);
        n_rst_i = 1'b1;
        @(negedge clk);
        check("ctrl_cwe", {uart_ce_o, uart_we_o, uart_sel_o}, 6'h3F);
        check("ctrl_addr", uart_addr_o, 32'h0);
        check("ctrl_data", uart_txdata_o, 32'h3);
        @(negedge clk);
        check("baud_addr", uart_addr_o, 32'h8);
        check("baud_data", uart_txdata_o, 32'h1B8);
        @(negedge clk);
        check("init_idle", uart_ce_o, 0);
        // single byte, cycle-exact
        @(posedge clk); #2;
        clr();
        q0.push_back({1'b0, 8'h55});
        @(negedge clk);
        @(negedge clk);
        check("b_poll", {uart_ce_o, uart_we_o, uart_addr_o[3:0]}, 6'b10_0100);
        check("b_grant", grant_o, 2'b01);
        @(negedge clk);
        check("b_waddr", uart_addr_o, 32'hC);
        check("b_wdata", uart_txdata_o, 32'h55);
        check("b_ready", req_ready_o, 2'b01);
        @(negedge clk);
        check("b_settle", {uart_ce_o, req_ready_o}, 0);
        check("b_settle_grant", grant_o, 2'b01);
        @(negedge clk);
        check("b_idle_grant", grant_o, 0);
        check("b_reads", n_reads, 1);
        // round robin, pointer now at requester 1
        clr();
        repeat (2) begin q0.push_back({1'b0, 8'hA0}); q1.push_back({1'b0, 8'hB1}); end
        drain("c_drain", 100);
        check("c_count", wr_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("c_data", wr_data[i], {24'h0, exp_c[i]});
            check("c_grant", wr_grant[i], {30'h0, exp_cg[i]});
        end
        for (int i = 0; i < 3; i++) check("c_gap", wr_cyc[i+1] - wr_cyc[i], 4);
        // locked burst from requester 1 while requester 0 waits
        clr();
        q1.push_back({1'b1, 8'hC1}); q1.push_back({1'b1, 8'hC2}); q1.push_back({1'b0, 8'hC3});
        q0.push_back({1'b0, 8'hD0}); q0.push_back({1'b0, 8'hD1});
        drain("d_drain", 100);
        check("d_count", wr_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("d_data", wr_data[i], {24'h0, exp_d[i]});
            check("d_grant", wr_grant[i], {30'h0, exp_dg[i]});
        end
        // lock held by an idle owner expires after 6 IDLE cycles, waiting request wins that cycle
        clr();
        q1.push_back({1'b1, 8'hE1});
        q0.push_back({1'b0, 8'hF0});
        drain("e_drain", 100);
        check("e_count", wr_data.size(), 2);
        check("e_data0", wr_data[0], 32'hE1);
        check("e_data1", wr_data[1], 32'hF0);
        check("e_grant1", wr_grant[1], 2'b01);
        check("e_gap", wr_cyc[1] - wr_cyc[0], 9);
        check("e_grant_end", grant_o, 0);
        // busy for 10 polls
        clr();
        busy_lim = busy_seen + 10;
        q0.push_back({1'b0, 8'h67});
        drain("f_drain", 100);
        check("f_reads", n_reads, 11);
        check("f_count", wr_data.size(), 1);
        check("f_data", wr_data[0], 32'h67);
        check("f_err", err_o, 0);
        // busy clears exactly when the counter reaches the timeout
        clr();
        busy_lim = busy_seen + 12;
        q1.push_back({1'b0, 8'h78});
        drain("g_drain", 100);
        check("g_reads", n_reads, 13);
        check("g_count", wr_data.size(), 1);
        check("g_err", err_o, 0);
        // permanent busy aborts
        clr();
        busy_lim = busy_seen + 100;
        q1.push_back({1'b0, 8'h9A});
        drain("h_drain", 100);
        check("h_reads", n_reads, 13);
        check("h_count", wr_data.size(), 0);
        check("h_err", err_o, 1);
        check("h_ready", n_ready[1], 1);
        busy_lim = busy_seen;
        // async reset while polling
        repeat (2) @(negedge clk);
        clr();
        busy_lim = busy_seen + 50;
        q0.push_back({1'b0, 8'hBC});
        begin
            int n = 0;
            while (!(uart_ce_o && !uart_we_o) && n < 50) begin @(negedge clk); n++; end
            check("i_poll_seen", n < 50, 1);
        end
        #2 n_rst_i = 1'b0;
        #1;
        check("i_rst_bus", {uart_ce_o, uart_we_o, uart_sel_o}, 0);
        check("i_rst_addr", uart_addr_o, 0);
        check("i_rst_grant", grant_o, 0);
        check("i_rst_err", err_o, 0);
        q0.delete();
        busy_lim = busy_seen;
        repeat (2) @(negedge clk);
        n_rst_i = 1'b1;
        repeat (5) @(negedge clk);
        check("i_wr_count", wr_data.size(), 2);
        check("i_ctrl", {wr_addr[0][7:0], wr_data[0][23:0]}, 32'h00_000003);
        check("i_baud", {wr_addr[1][7:0], wr_data[1][23:0]}, 32'h08_0001B8);
        check("i_no_ready", n_ready[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
